cbc_ctl_out: RTL and testbench

CBC_CTL_OUT -- requirements
Module: cbc_ctl_out

---
 rtl/cbc_ctl_out_pkg.sv | 30 +++
 rtl/cbc_ctl_out_if.sv | 41 ++++
 rtl/cbc_word_ser.sv | 56 +++++
 rtl/cbc_ctl_out.sv | 146 ++++++++++++++
 tb/tb_cbc_ctl_out.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/cbc_ctl_out_pkg.sv
// rtl/cbc_ctl_out_pkg.sv - shared encodings for the CBC output controller
//
// Holds the FSM state encoding, the framing tags carried in the two top
// bits of every output FIFO word, and the header field layout that the
// input-side controller decodes.
package cbc_ctl_out_pkg;

    localparam int AES_BLK_W     = 128;
    localparam int WORD_W        = 32;
    localparam int WORDS_PER_BLK = AES_BLK_W / WORD_W;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_HDR  = 3'd1;
    localparam logic [2:0] ST_WAIT = 3'd2;
    localparam logic [2:0] ST_SEND = 3'd3;
    localparam logic [2:0] ST_END  = 3'd4;

    localparam logic [1:0] TAG_HDR  = 2'b01;
    localparam logic [1:0] TAG_DATA = 2'b00;
    localparam logic [1:0] TAG_LAST = 2'b10;

    // Header payload: packet word count in the low bits, work mode
    // directly above it, zeros elsewhere.
    localparam int HDR_LEN_LSB = 0;

    function automatic int hdr_mode_pos(input int len_w);
        return HDR_LEN_LSB + len_w;
    endfunction

endpackage

// File: rtl/cbc_ctl_out_if.sv
// rtl/cbc_ctl_out_if.sv - signal bundle between the CBC output controller and its environment
//
// i_*  : packet control, AES core result, FIFO back-pressure (into the controller)
// o_*  : FIFO write strobe/word, block done, chaining value, busy, error
// slave  modport: the controller side
// master modport: the driving environment side
interface cbc_ctl_out_if
    import cbc_ctl_out_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 8
) ();

    logic                   i_start;
    logic                   i_mode;
    logic [LEN_W-1:0]       i_data_len;
    logic [AES_BLK_W-1:0]   i_iv;
    logic                   i_aes_valid;
    logic [AES_BLK_W-1:0]   i_aes_data;
    logic [AES_BLK_W-1:0]   i_cipher_in;
    logic                   i_full_fifo;
    logic                   o_wr_out;
    logic [DATA_W+1:0]      o_data_out;
    logic                   o_done_data;
    logic [AES_BLK_W-1:0]   o_data_chain;
    logic                   o_busy;
    logic                   o_error;

    modport slave (
        input  i_start, i_mode, i_data_len, i_iv, i_aes_valid, i_aes_data,
               i_cipher_in, i_full_fifo,
        output o_wr_out, o_data_out, o_done_data, o_data_chain, o_busy, o_error
    );

    modport master (
        output i_start, i_mode, i_data_len, i_iv, i_aes_valid, i_aes_data,
               i_cipher_in, i_full_fifo,
        input  o_wr_out, o_data_out, o_done_data, o_data_chain, o_busy, o_error
    );

endinterface

// File: rtl/cbc_word_ser.sv
// rtl/cbc_word_ser.sv - 128-bit block to 4x32-bit word serializer with stall
//
// clk, rst      : clock, synchronous active-high reset
// blk_tvalid    : load blk_tdata and restart at word 0
// blk_tdata     : 128-bit block
// active        : controller is in its send phase
// word_tready   : downstream can take a word this cycle
// word_tvalid   : a word is on offer (== active)
// word_tdata    : current word, least-significant 32 bits first
// word_tlast    : current word is the 4th of the block
module cbc_word_ser
    import cbc_ctl_out_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 blk_tvalid,
    input  logic [AES_BLK_W-1:0] blk_tdata,
    input  logic                 active,
    input  logic                 word_tready,
    output logic                 word_tvalid,
    output logic [WORD_W-1:0]    word_tdata,
    output logic                 word_tlast
);

    logic [AES_BLK_W-1:0] blk_q;
    logic [1:0]           cnt_q;

    assign word_tvalid = active;
    assign word_tlast  = (cnt_q == 2'd3);

    always_comb begin
        word_tdata = blk_q[31:0];
        case (cnt_q)
            2'd0: word_tdata = blk_q[31:0];
            2'd1: word_tdata = blk_q[63:32];
            2'd2: word_tdata = blk_q[95:64];
            2'd3: word_tdata = blk_q[127:96];
            default: word_tdata = blk_q[31:0];
        endcase
    end

    // The counter only moves on an accepted word, so a stalled word is
    // re-offered unchanged; it wraps 3->0 at the end of each block.
    always_ff @(posedge clk) begin
        if (rst) begin
            blk_q <= '0;
            cnt_q <= 2'd0;
        end else if (blk_tvalid) begin
            blk_q <= blk_tdata;
            cnt_q <= 2'd0;
        end else if (word_tvalid && word_tready) begin
            cnt_q <= cnt_q + 2'd1;
        end
    end

endmodule

// File: rtl/cbc_ctl_out.sv
// rtl/cbc_ctl_out.sv - CBC output controller: frames AES results into the output FIFO
//
// clk : clock, all state changes on the rising edge
// rst : synchronous active-high reset
// bus : cbc_ctl_out_if.slave
//       i_start/i_mode/i_data_len/i_iv open a packet; i_aes_valid/i_aes_data
//       deliver a block; i_cipher_in is the decrypt chaining source;
//       i_full_fifo stalls writes. o_wr_out/o_data_out write framed words
//       {tag, payload}; o_done_data marks the 4th word of a block;
//       o_data_chain is the next chaining value; o_busy, sticky o_error.
module cbc_ctl_out
    import cbc_ctl_out_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 8
) (
    input  logic clk,
    input  logic rst,
    cbc_ctl_out_if.slave bus
);

    localparam int              MODE_POS = hdr_mode_pos(LEN_W);
    localparam logic [LEN_W-3:0] BLK_ONE = {{(LEN_W-3){1'b0}}, 1'b1};

    logic [2:0]            state;
    logic                  mode_q;
    logic [LEN_W-1:0]      len_q;
    logic [LEN_W-3:0]      last_blk_q;
    logic [LEN_W-3:0]      blk_cnt;
    logic [AES_BLK_W-1:0]  chain_q;
    logic                  error_q;

    logic                  start_ok;
    logic                  capture;
    logic [AES_BLK_W-1:0]  out_blk;
    logic                  fifo_ready;
    logic                  hdr_wr;
    logic                  ser_tvalid;
    logic [WORD_W-1:0]     ser_tdata;
    logic                  ser_tlast;
    logic                  ser_wr;
    logic                  last_blk;
    logic [DATA_W-1:0]     payload;
    logic [DATA_W+1:0]     data_out;

    assign start_ok = bus.i_start && (bus.i_data_len != '0)
                      && (bus.i_data_len[1:0] == 2'b00);
    assign capture  = (state == ST_WAIT) && bus.i_aes_valid;

    // Decrypt un-chains against the value held before this capture edge.
    assign out_blk  = mode_q ? bus.i_aes_data : (bus.i_aes_data ^ chain_q);

    // Reset masks writes in the very cycle it is asserted.
    assign fifo_ready = !bus.i_full_fifo && !rst;
    assign hdr_wr     = (state == ST_HDR) && fifo_ready;
    assign ser_wr     = ser_tvalid && fifo_ready;
    assign last_blk   = (blk_cnt == last_blk_q);

    cbc_word_ser u_ser (
        .clk         (clk),
        .rst         (rst),
        .blk_tvalid  (capture),
        .blk_tdata   (out_blk),
        .active      (state == ST_SEND),
        .word_tready (fifo_ready),
        .word_tvalid (ser_tvalid),
        .word_tdata  (ser_tdata),
        .word_tlast  (ser_tlast)
    );

    always_comb begin
        payload  = '0;
        data_out = '0;
        if (hdr_wr) begin
            payload[HDR_LEN_LSB +: LEN_W] = len_q;
            payload[MODE_POS]             = mode_q;
            data_out = {TAG_HDR, payload};
        end else if (ser_wr) begin
            payload[WORD_W-1:0] = ser_tdata;
            data_out = {(last_blk && ser_tlast) ? TAG_LAST : TAG_DATA, payload};
        end
    end

    assign bus.o_wr_out     = hdr_wr || ser_wr;
    assign bus.o_data_out   = data_out;
    assign bus.o_done_data  = ser_wr && ser_tlast;
    assign bus.o_data_chain = chain_q;
    assign bus.o_busy       = (state != ST_IDLE);
    assign bus.o_error      = error_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            mode_q     <= 1'b0;
            len_q      <= '0;
            last_blk_q <= '0;
            blk_cnt    <= '0;
            chain_q    <= '0;
            error_q    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.i_start) begin
                        if (start_ok) begin
                            mode_q     <= bus.i_mode;
                            len_q      <= bus.i_data_len;
                            last_blk_q <= bus.i_data_len[LEN_W-1:2] - BLK_ONE;
                            blk_cnt    <= '0;
                            chain_q    <= bus.i_iv;
                            error_q    <= 1'b0;
                            state      <= ST_HDR;
                        end else begin
                            error_q <= 1'b1;
                        end
                    end
                end
                ST_HDR: begin
                    if (fifo_ready) state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.i_aes_valid) begin
                        chain_q <= mode_q ? bus.i_aes_data : bus.i_cipher_in;
                        state   <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (ser_wr && ser_tlast) begin
                        blk_cnt <= blk_cnt + BLK_ONE;
                        state   <= last_blk ? ST_END : ST_WAIT;
                    end
                end
                ST_END: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase

            // Protocol violations are ignored apart from raising the flag.
            if (bus.i_start && (state != ST_IDLE)) error_q <= 1'b1;
            if (bus.i_aes_valid && (state != ST_WAIT)) error_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cbc_ctl_out.sv
// tb/tb_cbc_ctl_out.sv - scoreboard testbench for cbc_ctl_out
module tb_cbc_ctl_out;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    int   cyc;
    int   done_cnt;
    int   done_cycle;
    int   aes_cyc;

    logic [33:0]  exp_q[$];
    logic         m_mode;
    logic [127:0] m_chain;
    int           m_nblk;
    int           m_blk;

    cbc_ctl_out_if #(.DATA_W(32), .LEN_W(8)) bus ();

    cbc_ctl_out #(.DATA_W(32), .LEN_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every FIFO write is popped against the scoreboard.
    always @(negedge clk) begin
        if (bus.o_wr_out === 1'b1) begin
            chk("wr_while_full", {127'd0, bus.i_full_fifo}, 128'd0);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got %h expected none", bus.o_data_out);
            end else begin
                chk("fifo_word", {94'd0, bus.o_data_out}, {94'd0, exp_q.pop_front()});
            end
        end
        if (bus.o_done_data === 1'b1) begin
            done_cnt++;
            done_cycle = cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_pkt(input logic mode, input logic [7:0] len,
                             input logic [127:0] iv, input bit ok);
        bus.i_start    = 1'b1;
        bus.i_mode     = mode;
        bus.i_data_len = len;
        bus.i_iv       = iv;
        if (ok) begin
            m_mode  = mode;
            m_chain = iv;
            m_nblk  = int'(len) / 4;
            m_blk   = 0;
            exp_q.push_back({2'b01, 23'd0, mode, len});
        end
        tick();
        bus.i_start = 1'b0;
        if (ok) tick();
    endtask

    task automatic push_block(input logic [127:0] aes, input logic [127:0] cipher);
        logic [127:0] blk;
        logic [1:0]   tag;
        blk     = m_mode ? aes : (aes ^ m_chain);
        m_chain = m_mode ? aes : cipher;
        m_blk++;
        for (int w = 0; w < 4; w++) begin
            tag = (m_blk == m_nblk && w == 3) ? 2'b10 : 2'b00;
            exp_q.push_back({tag, blk[w*32 +: 32]});
        end
    endtask

    task automatic pulse_aes(input logic [127:0] aes, input logic [127:0] cipher);
        bus.i_aes_valid = 1'b1;
        bus.i_aes_data  = aes;
        bus.i_cipher_in = cipher;
        aes_cyc = cyc;
        tick();
        bus.i_aes_valid = 1'b0;
    endtask

    task automatic send_block(input logic [127:0] aes, input logic [127:0] cipher);
        push_block(aes, cipher);
        pulse_aes(aes, cipher);
        repeat (4) tick();
    endtask

    task automatic chk_drained(input string name);
        chk(name, 128'(exp_q.size()), 128'd0);
    endtask

    localparam logic [127:0] BLK_A = 128'h33333333_22222222_11111111_00000000;
    localparam logic [127:0] BLK_B = 128'hdeadbeef_cafef00d_01234567_89abcdef;
    localparam logic [127:0] CIPH  = 128'h01234567_89abcdef_fedcba98_76543210;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        n_checks = 0; n_fail = 0; cyc = 0; done_cnt = 0; done_cycle = 0; aes_cyc = 0;
        m_mode = 1'b0; m_chain = '0; m_nblk = 0; m_blk = 0;
        bus.i_start = 1'b0; bus.i_mode = 1'b0; bus.i_data_len = '0; bus.i_iv = '0;
        bus.i_aes_valid = 1'b0; bus.i_aes_data = '0; bus.i_cipher_in = '0;
        bus.i_full_fifo = 1'b0;
        rst = 1'b1;
        repeat (3) tick();

        // Reset state
        chk("rst_busy",  {127'd0, bus.o_busy}, 128'd0);
        chk("rst_error", {127'd0, bus.o_error}, 128'd0);
        chk("rst_wr",    {127'd0, bus.o_wr_out}, 128'd0);
        chk("rst_done",  {127'd0, bus.o_done_data}, 128'd0);
        chk("rst_chain", bus.o_data_chain, 128'd0);
        chk("rst_data",  {94'd0, bus.o_data_out}, 128'd0);
        rst = 1'b0;
        tick();

        // Encrypt, len 8, IV 0, two blocks
        done_cnt = 0;
        start_pkt(1'b1, 8'd8, 128'd0, 1'b1);
        chk("hdr_written", 128'(exp_q.size()), 128'd0);
        send_block(BLK_A, CIPH);
        send_block(BLK_B, CIPH);
        chk("enc_busy_end", {127'd0, bus.o_busy}, 128'd1);
        tick();
        chk("enc_busy_idle", {127'd0, bus.o_busy}, 128'd0);
        chk("enc_done_cnt", 128'(done_cnt), 128'd2);
        chk("enc_chain", bus.o_data_chain, BLK_B);
        chk_drained("enc_drained");

        // Decrypt, len 4, IV all ones: words are 0F.. ^ FF.. = F0F0F0F0
        start_pkt(1'b0, 8'd4, {128{1'b1}}, 1'b1);
        bus.i_aes_valid = 1'b1;
        bus.i_aes_data  = {16{8'h0f}};
        bus.i_cipher_in = CIPH;
        exp_q.push_back({2'b00, 32'hf0f0f0f0});
        exp_q.push_back({2'b00, 32'hf0f0f0f0});
        exp_q.push_back({2'b00, 32'hf0f0f0f0});
        exp_q.push_back({2'b10, 32'hf0f0f0f0});
        tick();
        bus.i_aes_valid = 1'b0;
        repeat (5) tick();
        chk("dec_chain", bus.o_data_chain, CIPH);
        chk_drained("dec_drained");

        // FIFO full for 3 cycles while word 1 is pending
        start_pkt(1'b1, 8'd4, 128'd0, 1'b1);
        push_block(BLK_B, CIPH);
        pulse_aes(BLK_B, CIPH);
        tick();
        bus.i_full_fifo = 1'b1;
        repeat (3) tick();
        bus.i_full_fifo = 1'b0;
        repeat (3) tick();
        tick();
        chk("full_done_delay", 128'(done_cycle - aes_cyc), 128'd7);
        chk_drained("full_drained");

        // Bad lengths flag an error; a good start clears it
        start_pkt(1'b1, 8'd6, 128'd0, 1'b0);
        chk("len6_error", {127'd0, bus.o_error}, 128'd1);
        chk("len6_idle",  {127'd0, bus.o_busy}, 128'd0);
        start_pkt(1'b1, 8'd0, 128'd0, 1'b0);
        chk("len0_error", {127'd0, bus.o_error}, 128'd1);
        start_pkt(1'b1, 8'd4, 128'd5, 1'b1);
        chk("good_clears_err", {127'd0, bus.o_error}, 128'd0);
        send_block(BLK_A, CIPH);
        tick();
        chk_drained("len4_drained");

        // Reset after word 2 of block 1
        start_pkt(1'b1, 8'd8, 128'd0, 1'b1);
        push_block(BLK_A, CIPH);
        pulse_aes(BLK_A, CIPH);
        repeat (3) tick();
        rst = 1'b1;
        void'(exp_q.pop_back());
        tick();
        rst = 1'b0;
        chk("abort_busy",  {127'd0, bus.o_busy}, 128'd0);
        chk("abort_wr",    {127'd0, bus.o_wr_out}, 128'd0);
        chk("abort_chain", bus.o_data_chain, 128'd0);
        chk("abort_data",  {94'd0, bus.o_data_out}, 128'd0);
        chk_drained("abort_drained");
        start_pkt(1'b0, 8'd4, BLK_A, 1'b1);
        send_block(BLK_B, CIPH);
        tick();
        chk("post_abort_chain", bus.o_data_chain, CIPH);
        chk_drained("post_abort_drained");

        // Stray i_aes_valid during SEND
        start_pkt(1'b1, 8'd8, 128'd0, 1'b1);
        push_block(BLK_A, CIPH);
        pulse_aes(BLK_A, CIPH);
        tick();
        bus.i_aes_valid = 1'b1;
        bus.i_aes_data  = {4{32'h5a5a5a5a}};
        tick();
        bus.i_aes_valid = 1'b0;
        chk("stray_aes_error", {127'd0, bus.o_error}, 128'd1);
        repeat (2) tick();
        send_block(BLK_B, CIPH);
        tick();
        chk("stray_chain", bus.o_data_chain, BLK_B);
        chk("stray_busy", {127'd0, bus.o_busy}, 128'd0);
        chk_drained("stray_drained");

        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
